// File: rtl/adc_sram_spi_pkg.sv
// rtl/adc_sram_spi_pkg.sv - shared constants for the ADC capture SRAM SPI host
// Holds the capture-block register map, CONTROL bit positions, data widths,
// the host FSM state encoding and the latched command record.
package adc_sram_spi_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Capture-block register addresses
    localparam logic [2:0] REG_PRESCALER_LO = 3'd0;
    localparam logic [2:0] REG_PRESCALER_HI = 3'd1;
    localparam logic [2:0] REG_TRIG_LO      = 3'd2;
    localparam logic [2:0] REG_TRIG_HI      = 3'd3;
    localparam logic [2:0] REG_BUFF_LEN     = 3'd4;
    localparam logic [2:0] REG_CONTROL      = 3'd5;

    // CONTROL register bit positions
    localparam int CTRL_START_BIT         = 0;
    localparam int CTRL_START_READING_BIT = 1;

    // Host FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_CS_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    // Command captured at acceptance; tx is the 16-bit write frame, LSB first
    typedef struct packed {
        logic        rd;
        logic [15:0] tx;
        logic [15:0] words;
    } cmd_t;

endpackage

// File: rtl/spi_host_timer.sv
// rtl/spi_host_timer.sv - reloadable down-counter with one-cycle expire pulse
// Ports: clk, rst_n (async, active-low); load/load_val start a period of
// load_val cycles; expire is high in the last cycle of that period.
module spi_host_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        expire   = active_q && (count_q == '0);
        // A reload takes priority so the owner can start the next period
        // in the same cycle the current one expires.
        if (load) begin
            count_d  = load_val - CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/adc_sram_spi_host.sv
// rtl/adc_sram_spi_host.sv - SPI host for register writes and buffer reads
// Ports: clk, rst_n (async, active-low); command side cmd_valid/cmd_ready with
// cmd_read, cmd_addr, cmd_data, cmd_words; read side rd_data/rd_valid; busy;
// SPI side spi_sclk, spi_mosi, spi_cs_n, spi_miso (asynchronous input).
module adc_sram_spi_host
    import adc_sram_spi_pkg::*;
#(
    parameter int SCLK_HALF = 6,
    parameter int CS_GAP    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_read,
    input  logic [2:0]         cmd_addr,
    input  logic [BYTE_W-1:0]  cmd_data,
    input  logic [15:0]        cmd_words,
    output logic [WORD_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               spi_sclk,
    output logic               spi_mosi,
    output logic               spi_cs_n,
    input  logic               spi_miso
);

    logic [2:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              mosi_q, mosi_d;
    logic              miso_s1_q, miso_s2_q;

    logic              tmr_load;
    logic [7:0]        tmr_val;
    logic              tmr_expire;
    logic              last_bit;
    logic [4:0]        next_bit;

    spi_host_timer #(.CNT_W(8)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign next_bit = bit_cnt_q + 5'd1;
    // Reads finish on the 32nd bit of the final word; writes after 16 bits.
    assign last_bit = cmd_q.rd ? ((bit_cnt_q == 5'd31) && (16'(word_cnt_q + 16'd1) == cmd_q.words))
                               : (bit_cnt_q == 5'd15);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.rd    = cmd_read;
                    cmd_d.tx    = {cmd_data, 5'd0, cmd_addr};
                    cmd_d.words = cmd_words;
                    bit_cnt_d   = 5'd0;
                    word_cnt_d  = 16'd0;
                    // A zero-length read is consumed without touching the bus.
                    if (!cmd_read || (cmd_words != 16'd0)) begin
                        state_d = ST_CS_SETUP;
                    end
                end
            end
            ST_CS_SETUP: begin
                if (tmr_expire) begin
                    state_d = ST_SHIFT_HI;
                    mosi_d  = cmd_q.rd ? 1'b0 : cmd_q.tx[bit_cnt_q[3:0]];
                end
            end
            ST_SHIFT_HI: begin
                if (tmr_expire) begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (tmr_expire) begin
                    if (cmd_q.rd) begin
                        rx_d[bit_cnt_q] = miso_s2_q;
                        if (bit_cnt_q == 5'd31) begin
                            rd_data_d  = rx_d;
                            rd_valid_d = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    end
                    bit_cnt_d = next_bit;
                    if (last_bit) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        state_d = ST_SHIFT_HI;
                        mosi_d  = cmd_q.rd ? 1'b0 : cmd_q.tx[next_bit[3:0]];
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tmr_expire) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every timed state is entered through a state change, so the timer
        // is armed exactly on entry.
        tmr_load = (state_d != state_q) && (state_d != ST_IDLE);
        tmr_val  = (state_d == ST_GAP) ? 8'(CS_GAP) : 8'(SCLK_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            mosi_q     <= mosi_d;
            miso_s1_q  <= spi_miso;
            miso_s2_q  <= miso_s1_q;
        end
    end

    // Bus outputs decode straight from the state flop so an asynchronous
    // reset releases chip select and parks SCLK in the same instant.
    assign spi_cs_n  = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT_HI) ||
                         (state_q == ST_SHIFT_LO) || (state_q == ST_CS_HOLD));
    assign spi_sclk  = (state_q == ST_SHIFT_HI);
    assign spi_mosi  = mosi_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: doc/adc_sram_spi_host.md
ADC_SRAM_SPI_HOST -- requirements
Module: adc_sram_spi_host

Interface
REQ-001 SCLK_HALF, 6, clk cycles per SCLK half-period; SHALL be >=6.
REQ-002 CS_GAP, 8, minimum clk cycles spi_cs_n stays high between transactions.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-007 cmd_read  in  1  0 = register write, 1 = buffer read.
REQ-008 cmd_addr  in  3  register address for writes.
REQ-009 cmd_data  in  8  register value for writes.
REQ-010 cmd_words  in  16  number of 32-bit words to read.
REQ-011 rd_data  out  32  last received word.
REQ-012 rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 spi_sclk  out  1  SPI clock; idles low.
REQ-015 spi_mosi  out  1  serial data to the capture block.
REQ-016 spi_cs_n  out  1  active-low chip select.
REQ-017 spi_miso  in  1  serial data from the capture block; asynchronous.

Function
REQ-018 Command fields SHALL be latched on acceptance; later input changes SHALL have no effect.
REQ-019 FSM states: IDLE, CS_SETUP, SHIFT_HI, SHIFT_LO, CS_HOLD, GAP.
- IDLE -> CS_SETUP on acceptance.
- CS_SETUP: spi_cs_n=0 for SCLK_HALF cycles -> SHIFT_HI.
- SHIFT_HI: spi_sclk=1 for SCLK_HALF cycles -> SHIFT_LO.
- SHIFT_LO: spi_sclk=0 for SCLK_HALF cycles -> SHIFT_HI, or CS_HOLD after the last bit.
- CS_HOLD: SCLK_HALF cycles -> GAP.
- GAP: spi_cs_n=1 for CS_GAP cycles -> IDLE.
REQ-020 Bit order SHALL be LSB-first on both lines.
REQ-021 spi_mosi SHALL change only on entry to SHIFT_HI, so the capture block samples it on the falling edge.
REQ-022 Write transaction: exactly 16 SCLK pulses; cmd_addr zero-extended to 8 bits, then cmd_data.
REQ-023 Read transaction: exactly 32*cmd_words SCLK pulses; spi_mosi held 0.
REQ-024 spi_miso SHALL pass through a 2-flop synchronizer. The synchronized value SHALL be sampled in the last cycle of each SHIFT_LO as bit (n mod 32), where n is the falling-edge index from 0.
REQ-025 After each 32nd sampled bit, the assembled word SHALL load rd_data and rd_valid SHALL pulse for exactly one cycle; words SHALL be delivered in order.
REQ-026 The bit counter SHALL be 5 bits and the word counter 16 bits. Read ends when the word counter reaches cmd_words, with no wrap (65535 words legal).
REQ-027 cmd_words=0 read SHALL be accepted and return to IDLE next cycle: no spi_cs_n assertion, no SCLK edges, no rd_valid.
REQ-028 cmd_valid while busy SHALL be ignored (cmd_ready=0); no queueing.
REQ-029 rd_valid SHALL never assert during write transactions.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rd_valid=0, rd_data=0, busy=0, counters 0. cmd_ready=1 after release.
REQ-031 Reset mid-transaction SHALL abort it immediately: no further SCLK edges, no rd_valid for a partial word.

Structure
REQ-032 Package adc_sram_spi_pkg SHALL hold the register address constants (PRESCALER_LO=0, PRESCALER_HI=1, TRIG_LO=2, TRIG_HI=3, BUFF_LEN=4, CONTROL=5), the CONTROL bit positions (start=bit0, start_reading=bit1), byte width 8, word width 32 and the FSM state encoding.
REQ-033 One sub-module, spi_host_timer: a half-period/gap down-counter issuing a one-cycle expire pulse; everything else inline.

Verification
REQ-034 Write addr=4, data=0x03 -> 16 pulses; MOSI bits 0,0,1,0,0,0,0,0, 1,1,0,0,0,0,0,0; spi_cs_n low throughout, then >=8 cycles high.
REQ-035 Read cmd_words=2, MISO model LSB-first 0xA5A50F0F then 0x12345678 -> exactly 64 pulses; rd_valid twice with those values in order.
REQ-036 Read cmd_words=0 -> cmd_ready back high next cycle; spi_cs_n never low; no rd_valid.
REQ-037 rst_n low after pulse 20 of a 32-pulse read -> spi_cs_n=1, spi_sclk=0 same cycle; no rd_valid; next command runs normally.
REQ-038 cmd_valid held high through a write -> second command accepted only after GAP, with >=CS_GAP cycles between transactions.
REQ-039 Write CONTROL=0x02, then read 512 words against the capture-block model -> 512 rd_valid pulses matching the buffer contents.
